// File: rtl/lenet_pkg.sv
// Shared definitions for the lenet frame path: default pixel/frame geometry
// and the ping-pong bank index type.
package lenet_pkg;

    localparam int LENET_PIX_W = 32;
    localparam int LENET_IMG_W = 32;
    localparam int LENET_IMG_H = 32;

    typedef logic bank_idx_t;

    function automatic logic [1:0] full_count(input logic [1:0] full);
        return {1'b0, full[0]} + {1'b0, full[1]};
    endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// One frame bank: a single-write-port RAM with a registered, enable-gated read
// port. Contents are never reset.
module frame_bank_ram #(
    parameter int PIX_W = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [PIX_W-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [PIX_W-1:0] o_rdata
);

    logic [PIX_W-1:0] r_mem [DEPTH];
    logic [PIX_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/src_frame_buf.sv
// Ping-pong frame buffer between a raster pixel producer and the lenet
// consumer: one bank fills while the other is read, with handoff by full flags.
module src_frame_buf
    import lenet_pkg::*;
#(
    parameter int PIX_W = LENET_PIX_W,
    parameter int IMG_W = LENET_IMG_W,
    parameter int IMG_H = LENET_IMG_H,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             wr_valid,
    input  logic [PIX_W-1:0] wr_data,
    output logic             wr_ready,
    input  logic             cena,
    input  logic [AW-1:0]    aa,
    output logic [PIX_W-1:0] qa,
    output logic             frame_valid,
    input  logic             rd_done,
    output logic [1:0]       frames_pending
);

    localparam int N      = IMG_W * IMG_H;
    localparam int RAM_AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] LAST_PIX = AW'(N - 1);
    localparam logic [AW:0]   N_EXT    = (AW + 1)'(N);

    logic [1:0]       r_full;
    bank_idx_t        r_wr_bank;
    bank_idx_t        r_rd_bank;
    logic [AW-1:0]    r_wr_cnt;
    logic [1:0]       r_pending;
    logic             r_qa_zero;
    bank_idx_t        r_qa_sel;

    logic             w_wr_fire;
    logic             w_last;
    logic             w_rd_fire;
    logic             w_pad;
    logic [1:0]       w_full_nxt;
    logic [PIX_W-1:0] w_q [2];

    assign wr_ready       = !r_full[r_wr_bank] && !flush;
    assign frame_valid    = r_full[r_rd_bank];
    assign frames_pending = r_pending;

    always_comb begin
        w_wr_fire  = wr_valid && wr_ready;
        w_last     = w_wr_fire && (r_wr_cnt == LAST_PIX);
        w_rd_fire  = rd_done && frame_valid && !flush;
        w_pad      = ({1'b0, aa} >= N_EXT);
        w_full_nxt = r_full;
        // Completion and release always hit different banks, so both apply.
        if (w_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_fire) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_full    <= '0;
            r_wr_bank <= '0;
            r_rd_bank <= '0;
            r_wr_cnt  <= '0;
            r_pending <= '0;
            r_qa_zero <= 1'b1;
            r_qa_sel  <= '0;
        end else if (flush) begin
            r_full    <= '0;
            r_wr_bank <= '0;
            r_rd_bank <= '0;
            r_wr_cnt  <= '0;
            r_pending <= '0;
            r_qa_zero <= 1'b1;
            r_qa_sel  <= '0;
        end else begin
            r_full    <= w_full_nxt;
            r_pending <= full_count(w_full_nxt);
            if (w_wr_fire) begin
                if (w_last) begin
                    r_wr_cnt  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_cnt  <= r_wr_cnt + AW'(1);
                end
            end
            if (w_rd_fire) begin
                r_rd_bank <= ~r_rd_bank;
            end
            // Output select/pad flags track the RAM read so qa holds with cena high.
            if (!cena) begin
                r_qa_zero <= w_pad;
                r_qa_sel  <= r_rd_bank;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        frame_bank_ram #(
            .PIX_W (PIX_W),
            .DEPTH (N),
            .AW    (RAM_AW)
        ) u_ram (
            .clk     (clk),
            .i_we    (w_wr_fire && (r_wr_bank == bank_idx_t'(g))),
            .i_waddr (r_wr_cnt[RAM_AW-1:0]),
            .i_wdata (wr_data),
            .i_re    (!cena && !flush && !w_pad && (r_rd_bank == bank_idx_t'(g))),
            .i_raddr (aa[RAM_AW-1:0]),
            .o_rdata (w_q[g])
        );
    end

    assign qa = r_qa_zero ? '0 : w_q[r_qa_sel];

endmodule

// File: tb/tb_src_frame_buf.sv
// Bench for src_frame_buf: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a frame-level model.
module tb_src_frame_buf;

    localparam int PIX_W = 32;
    localparam int IMG_W = 32;
    localparam int IMG_H = 32;
    localparam int AW    = 11;
    localparam int N     = IMG_W * IMG_H;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             flush = 1'b0;
    logic             wr_valid = 1'b0;
    logic [PIX_W-1:0] wr_data = '0;
    logic             wr_ready;
    logic             cena = 1'b1;
    logic [AW-1:0]    aa = '0;
    logic [PIX_W-1:0] qa;
    logic             frame_valid;
    logic             rd_done = 1'b0;
    logic [1:0]       frames_pending;

    int n_checks = 0;
    int n_fail   = 0;

    src_frame_buf #(
        .PIX_W (PIX_W),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .flush          (flush),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .cena           (cena),
        .aa             (aa),
        .qa             (qa),
        .frame_valid    (frame_valid),
        .rd_done        (rd_done),
        .frames_pending (frames_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: two pixel arrays with full flags and pointers.
    logic [PIX_W-1:0] m_mem [2][N];
    bit               m_full [2];
    int               m_wb, m_rb, m_cnt;
    logic [PIX_W-1:0] m_qa;
    bit               m_qa_chk;
    bit               m_fv_old;

    always @(posedge clk or posedge rstn) begin
        if (rstn) begin
            m_full[0] = 0; m_full[1] = 0;
            m_wb = 0; m_rb = 0; m_cnt = 0;
            m_qa = '0; m_qa_chk = 1;
        end else if (flush) begin
            m_full[0] = 0; m_full[1] = 0;
            m_wb = 0; m_rb = 0; m_cnt = 0;
            m_qa = '0; m_qa_chk = 1;
        end else begin
            if (!cena) begin
                if (int'(aa) >= N) begin
                    m_qa = '0;
                    m_qa_chk = 1;
                end else begin
                    m_qa = m_mem[m_rb][int'(aa)];
                    m_qa_chk = m_full[m_rb];
                end
            end
            m_fv_old = m_full[m_rb];
            if (wr_valid && !m_full[m_wb]) begin
                m_mem[m_wb][m_cnt] = wr_data;
                m_cnt++;
                if (m_cnt == N) begin
                    m_full[m_wb] = 1;
                    m_wb = 1 - m_wb;
                    m_cnt = 0;
                end
            end
            if (rd_done && m_fv_old) begin
                m_full[m_rb] = 0;
                m_rb = 1 - m_rb;
            end
        end
    end

    always @(negedge clk) begin
        chk("wr_ready", 32'(wr_ready), 32'(!m_full[m_wb] && !flush));
        chk("frame_valid", 32'(frame_valid), 32'(m_full[m_rb]));
        chk("frames_pending", 32'(frames_pending), 32'(m_full[0]) + 32'(m_full[1]));
        if (m_qa_chk) chk("qa", qa, m_qa);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // mode 0: constant base, 1: base+i, 2: i&255
    task automatic write_px(input int n, input logic [31:0] base, input int mode);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = (mode == 0) ? base : (mode == 1) ? base + 32'(i) : 32'(i & 255);
            cyc();
        end
        wr_valid = 1'b0;
    endtask

    task automatic rd(input int addr);
        cena = 1'b0;
        aa   = AW'(addr);
        cyc();
        cena = 1'b1;
    endtask

    task automatic pulse_done();
        rd_done = 1'b1;
        cyc();
        rd_done = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);
        chk("reset_fv", 32'(frame_valid), 32'd0);
        chk("reset_pending", 32'(frames_pending), 32'd0);
        chk("reset_qa", qa, 32'd0);
        rstn = 1'b0;
        cyc();

        // First frame of i&255
        write_px(N - 1, 32'd0, 2);
        chk("fv_before_last", 32'(frame_valid), 32'd0);
        wr_valid = 1'b1; wr_data = 32'(1023 & 255);
        cyc();
        wr_valid = 1'b0;
        chk("fv_after_last", 32'(frame_valid), 32'd1);
        chk("pending_one", 32'(frames_pending), 32'd1);
        rd(37);
        chk("qa_aa37", qa, 32'd37);
        pulse_done();
        chk("pending_released", 32'(frames_pending), 32'd0);

        // Two frames without release
        write_px(N, 32'd5, 0);
        write_px(N, 32'd9, 0);
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        chk("full_pending", 32'(frames_pending), 32'd2);
        wr_valid = 1'b1; wr_data = 32'd77;
        chk("third_not_ready", 32'(wr_ready), 32'd0);
        cyc();
        wr_valid = 1'b0;
        chk("third_pending", 32'(frames_pending), 32'd2);
        pulse_done();
        rd(0);
        chk("after_done_qa", qa, 32'd9);
        chk("after_done_ready", 32'(wr_ready), 32'd1);

        // Completion coincident with release
        write_px(N - 1, 32'hA000, 1);
        chk("pre_coinc_pending", 32'(frames_pending), 32'd1);
        wr_valid = 1'b1; wr_data = 32'hA3FF; rd_done = 1'b1;
        cyc();
        wr_valid = 1'b0; rd_done = 1'b0;
        chk("coinc_pending", 32'(frames_pending), 32'd1);
        chk("coinc_fv", 32'(frame_valid), 32'd1);
        rd(0);
        chk("coinc_rd_bank1", qa, 32'hA000);

        // Boundary reads and hold
        rd(1023);
        chk("qa_last", qa, 32'hA3FF);
        cena = 1'b1; aa = AW'(5);
        cyc();
        chk("qa_hold", qa, 32'hA3FF);
        rd(1024);
        chk("qa_pad", qa, 32'd0);

        // Reset mid-frame
        pulse_done();
        write_px(500, 32'hDEAD0000, 1);
        rstn = 1'b1;
        cyc();
        rstn = 1'b0;
        write_px(N, 32'hB000, 1);
        chk("rst_pending", 32'(frames_pending), 32'd1);
        chk("rst_fv", 32'(frame_valid), 32'd1);
        rd(0);
        chk("rst_pix0", qa, 32'hB000);

        // Flush on the last pixel
        write_px(N - 1, 32'hE000, 1);
        wr_valid = 1'b1; wr_data = 32'hE3FF; flush = 1'b1;
        cyc();
        wr_valid = 1'b0; flush = 1'b0;
        chk("flush_pending", 32'(frames_pending), 32'd0);
        chk("flush_fv", 32'(frame_valid), 32'd0);
        chk("flush_qa", qa, 32'd0);
        write_px(N - 1, 32'hC000, 1);
        chk("flush_restart_fv0", 32'(frame_valid), 32'd0);
        write_px(1, 32'hC3FF, 0);
        chk("flush_restart_fv1", 32'(frame_valid), 32'd1);
        rd(0);
        chk("flush_pix0", qa, 32'hC000);

        // Randomized traffic
        for (int c = 0; c < 6000; c++) begin
            wr_valid = ($urandom_range(99) < 70);
            wr_data  = $urandom;
            rd_done  = ($urandom_range(99) < 3);
            cena     = ($urandom_range(1) == 0);
            aa       = AW'($urandom_range(1100));
            flush    = ($urandom_range(999) == 0);
            cyc();
        end
        wr_valid = 1'b0; rd_done = 1'b0; cena = 1'b1; flush = 1'b0;
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
